// File: rtl/snd_synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snd_pkg
// Description : Shared types and constants for the four-voice tone generator.
// Revision    : 1.0 - initial release
// ============================================================================
package snd_pkg;

    localparam logic [1:0] P_PERIOD = 2'd0;
    localparam logic [1:0] P_VOLUME = 2'd1;
    localparam logic [1:0] P_DUR    = 2'd2;
    localparam logic [1:0] P_CTRL   = 2'd3;

    localparam int          NUM_VOICES    = 4;
    localparam logic [14:0] c_LFSR_SEED   = 15'h7FFF;
    localparam int          c_LFSR_TAP_HI = 14;
    localparam int          c_LFSR_TAP_LO = 13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_V0   = 3'd1,
        S_V1   = 3'd2,
        S_V2   = 3'd3,
        S_V3   = 3'd4,
        S_MIX  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  volume;
        logic [15:0] dur;
        logic [15:0] rem;
        logic        gate;
        logic        noise;
        logic [15:0] phase;
        logic        level;
        logic [14:0] lfsr;
    } voice_t;

    function automatic voice_t voice_reset();
        voice_t v;
        v      = '0;
        v.lfsr = c_LFSR_SEED;
        return v;
    endfunction

    // Signed contribution of one voice to the mix; silent voices add nothing.
    function automatic logic signed [10:0] voice_contrib(input voice_t v);
        logic signed [10:0] mag;
        mag = signed'({3'b000, v.volume});
        if (!v.gate || (v.period == '0)) begin
            return '0;
        end
        return v.level ? mag : -mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snd_synth_if.sv
`default_nettype none
// ============================================================================
// Module      : snd_synth_if
// Description : CPU sound write port and mixed-sample output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface snd_synth_if;
    logic               snd_wen;
    logic [1:0]         w_param;
    logic [10:0]        w_index;
    logic [15:0]        w_val;
    logic signed [10:0] sample_out;
    logic               sample_valid;
    logic [3:0]         voice_done;

    modport master (
        output snd_wen, w_param, w_index, w_val,
        input  sample_out, sample_valid, voice_done
    );

    modport slave (
        input  snd_wen, w_param, w_index, w_val,
        output sample_out, sample_valid, voice_done
    );
endinterface
`default_nettype wire

// File: rtl/snd_synth_voice_step.sv
`default_nettype none
// ============================================================================
// Module      : snd_voice_step
// Description : Combinational one-sample advance of a single voice.
// Revision    : 1.0 - initial release
// ============================================================================
module snd_voice_step
    import snd_pkg::*;
(
    input  voice_t cur,
    input  logic   ms_tick,
    output voice_t nxt,
    output logic   done
);

    logic [15:0] w_phase_inc;
    logic [14:0] w_lfsr_shift;

    assign w_phase_inc  = cur.phase + 16'd1;
    assign w_lfsr_shift = {cur.lfsr[13:0], cur.lfsr[c_LFSR_TAP_HI] ^ cur.lfsr[c_LFSR_TAP_LO]};

    always_comb begin
        nxt  = cur;
        done = 1'b0;
        if (cur.gate && (cur.period != '0)) begin
            if (w_phase_inc == cur.period) begin
                nxt.phase = '0;
                if (cur.noise) begin
                    nxt.lfsr  = w_lfsr_shift;
                    nxt.level = w_lfsr_shift[0];
                end else begin
                    nxt.level = ~cur.level;
                end
            end else begin
                nxt.phase = w_phase_inc;
            end
            // Duration of zero never counts down, so the voice plays until ungated.
            if (ms_tick && (cur.rem != '0)) begin
                nxt.rem = cur.rem - 16'd1;
                if (cur.rem == 16'd1) begin
                    nxt.gate = 1'b0;
                    done     = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snd_synth.sv
`default_nettype none
// ============================================================================
// Module      : snd_synth
// Description : Four-voice square/noise tone generator with signed mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module snd_synth
    import snd_pkg::*;
#(
    parameter int SAMPLE_DIV = 1042,
    parameter int DUR_DIV    = 48
) (
    input  logic        clk,
    input  logic        reset,
    snd_synth_if.slave  snd
);

    localparam int                 c_SMP_W    = $clog2(SAMPLE_DIV + 1);
    localparam int                 c_DUR_W    = $clog2(DUR_DIV + 1);
    localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'(SAMPLE_DIV - 1);
    localparam logic [c_DUR_W-1:0] c_DUR_LAST = c_DUR_W'(DUR_DIV - 1);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [c_SMP_W-1:0] r_smp_cnt;
    logic [c_DUR_W-1:0] r_dur_cnt;
    logic               r_ms_tick;
    logic               w_tick;

    voice_t [NUM_VOICES-1:0] r_voice;
    voice_t [NUM_VOICES-1:0] w_voice_nxt;
    logic   [NUM_VOICES-1:0] w_done;

    voice_t      w_step_cur;
    voice_t      w_step_nxt;
    logic        w_step_done;
    logic        w_step_en;
    logic [1:0]  w_step_sel;
    logic        w_mix_en;

    logic signed [10:0]      w_mix_sum;
    logic signed [10:0]      r_sample;
    logic                    r_valid;
    logic [NUM_VOICES-1:0]   r_done;

    logic w_unused_idx;
    assign w_unused_idx = ^snd.w_index[10:2];

    assign w_tick = (r_smp_cnt == c_SMP_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_smp_cnt <= '0;
        end else begin
            r_smp_cnt <= r_smp_cnt + c_SMP_W'(1);
        end
    end

    // ms_tick is latched at the tick so it stays stable for the whole V0..V3 sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dur_cnt <= '0;
            r_ms_tick <= 1'b0;
        end else if (w_tick) begin
            r_ms_tick <= (r_dur_cnt == c_DUR_LAST);
            r_dur_cnt <= (r_dur_cnt == c_DUR_LAST) ? '0 : r_dur_cnt + c_DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_en   = 1'b0;
        w_step_sel  = 2'd0;
        w_mix_en    = 1'b0;
        case (r_state)
            S_IDLE: if (w_tick) w_state_nxt = S_V0;
            S_V0: begin
                w_step_en   = 1'b1;
                w_step_sel  = 2'd0;
                w_state_nxt = S_V1;
            end
            S_V1: begin
                w_step_en   = 1'b1;
                w_step_sel  = 2'd1;
                w_state_nxt = S_V2;
            end
            S_V2: begin
                w_step_en   = 1'b1;
                w_step_sel  = 2'd2;
                w_state_nxt = S_V3;
            end
            S_V3: begin
                w_step_en   = 1'b1;
                w_step_sel  = 2'd3;
                w_state_nxt = S_MIX;
            end
            S_MIX: begin
                w_mix_en    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_step_cur = r_voice[w_step_sel];

    snd_voice_step u_step (
        .cur     (w_step_cur),
        .ms_tick (r_ms_tick),
        .nxt     (w_step_nxt),
        .done    (w_step_done)
    );

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic   w_stepping;
        logic   w_wr;
        logic   w_discard;
        voice_t w_base;
        voice_t w_nxt;

        assign w_stepping = w_step_en && (w_step_sel == 2'(v));
        assign w_wr       = snd.snd_wen && (snd.w_index[1:0] == 2'(v));
        // Period and control writes throw away a colliding step entirely.
        assign w_discard  = w_wr && ((snd.w_param == P_PERIOD) || (snd.w_param == P_CTRL));
        assign w_base     = (w_stepping && !w_discard) ? w_step_nxt : r_voice[v];
        assign w_done[v]  = w_stepping && !w_discard && w_step_done;

        always_comb begin
            w_nxt = w_base;
            if (w_wr) begin
                case (snd.w_param)
                    P_PERIOD: begin
                        w_nxt.period = snd.w_val;
                        w_nxt.phase  = '0;
                    end
                    P_VOLUME: w_nxt.volume = snd.w_val[7:0];
                    P_DUR: begin
                        w_nxt.dur = snd.w_val;
                        w_nxt.rem = snd.w_val;
                    end
                    default: begin
                        w_nxt.gate  = snd.w_val[0];
                        w_nxt.noise = snd.w_val[1];
                        if (!r_voice[v].gate && snd.w_val[0]) begin
                            w_nxt.phase = '0;
                            w_nxt.level = 1'b0;
                            w_nxt.rem   = r_voice[v].dur;
                            w_nxt.lfsr  = c_LFSR_SEED;
                        end
                    end
                endcase
            end
        end

        assign w_voice_nxt[v] = w_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_voice <= {NUM_VOICES{voice_reset()}};
        end else begin
            r_voice <= w_voice_nxt;
        end
    end

    assign w_mix_sum = voice_contrib(r_voice[0]) + voice_contrib(r_voice[1])
                     + voice_contrib(r_voice[2]) + voice_contrib(r_voice[3]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_done   <= '0;
        end else begin
            r_valid <= w_mix_en;
            r_done  <= w_done;
            if (w_mix_en) begin
                r_sample <= w_mix_sum;
            end
        end
    end

    assign snd.sample_out   = r_sample;
    assign snd.sample_valid = r_valid;
    assign snd.voice_done   = r_done;

endmodule
`default_nettype wire
